ber_mask_gen: RTL and testbench
===============================

# ber_mask_gen

Parametrised bit-error-rate (BER) fault-injection mask generator for the cache subsystem. On each access request it produces a registered XOR mask for the data path. It supports four modes:
- off;
- independent per-bit random errors;
- spatially contiguous bursts that repeat over several accesses (weak/stuck cell model);
- exactly one flipped bit per triggered access.

It also keeps saturating statistics of injected accesses and flipped bits for the test harness.

## Interface
Parameters:
- Width, 64: mask width in bits; one LFSR lane per bit; must be a power of two, ≥ 2.
- LfsrWidth, 64: width of each lane's LFSR and of ber_i.
- SeedBase, 1: lane k resets to SeedBase+k; must keep every seed nonzero.
- HoldW, 8: width of hold_i.
- CntW, 32: width of statistics counters.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_i, in, 1: access strobe; samples config, advances LFSRs, launches one mask.
- mode_i, in, 2: 0 OFF, 1 RANDOM, 2 BURST, 3 SINGLE.
- ber_i, in, LfsrWidth: unsigned threshold; a lane fires when its LFSR value < ber_i.
- burst_len_i, in, $clog2(Width)+1: spatial burst length; 0 is treated as 1; values > Width clamp to Width.
- hold_i, in, HoldW: extra accesses that repeat a burst mask.
- clr_cnt_i, in, 1: synchronous clear of both counters.
- mask_o, out, Width: registered mask.
- mask_valid_o, out, 1: mask_o corresponds to the previous cycle's req_i.
- inj_cnt_o, out, CntW: count of valid masks that were nonzero, saturating.
- flip_cnt_o, out, CntW: sum of popcount(mask) over valid masks, saturating.

## Operation
- Lane k is an LFSR of LfsrWidth bits, seeded SeedBase+k. The lane value used on a request is its current state. The lane then steps once, on that req_i, whenever mode_i ≠ OFF. With mode_i = OFF the lanes hold.
- The trigger comes from lane 0. The start/bit index comes from lane 1's low $clog2(Width) bits.
- OFF: next mask = 0. The state machine is forced to IDLE.
- RANDOM: mask bit k = (lane k < ber_i).
- SINGLE: if trigger, one-hot at the index; else 0.
- BURST, with states IDLE and HOLD:
  - IDLE, trigger: mask has the effective burst_len_i consecutive bits set from the index upward, wrapping modulo Width. The mask is latched in a burst register. If hold_i > 0, load hold counter = hold_i and go to HOLD.
  - IDLE, no trigger: mask 0.
  - HOLD, on each req_i: emit the latched mask and decrement the counter. Go to IDLE when it reaches 0. No trigger is evaluated in HOLD, but the lanes still step.
  - A mode_i change away from BURST while in HOLD aborts to IDLE. That request is served per the new mode.
- ber_i = 0 never fires. Lane values are never 0, so ber_i = 1 never fires either.
- Counters update only on cycles where mask_valid_o is set and mask_o ≠ 0.
  - inj_cnt_o += 1.
  - flip_cnt_o += popcount(mask_o), clamped at all-ones.
- clr_cnt_i takes priority over a same-cycle update; the result is 0.

## Timing
- Reset: all lanes at their seeds; state IDLE; hold counter 0; burst register 0; mask_o 0; mask_valid_o 0; both counters 0.
- Latency is 1. req_i at edge t gives mask_o/mask_valid_o valid after edge t+1. mask_valid_o is high for exactly one cycle per req_i.
- mask_o holds its last value when there is no req_i.
- Back-to-back req_i is supported every cycle; throughput is 1 mask per cycle.
- Counters reflect a mask one cycle after it appears on mask_o.
- Reset asserted mid-HOLD returns everything to the reset values immediately (asynchronous).

## Structure
- Shared package ber_pkg:
  - ber_mode_e enum (OFF/RANDOM/BURST/SINGLE);
  - burst_state_e (IDLE/HOLD);
  - helper function for the wrapped contiguous-run mask.
- Lanes instantiate the existing lfsr sub-module, Width copies, with OutWidth=LfsrWidth, RstVal=SeedBase+k, CipherLayers=0, and en_i tied to req_i && mode_i ≠ OFF.
- The popcount is a local function; no further sub-modules.

## Test plan
- RANDOM, defaults, ber_i = 33, single req after reset -> mask_o = 0x0000_0000_FFFF_FFFF, mask_valid_o pulse, inj_cnt_o = 1, flip_cnt_o = 32.
- RANDOM, ber_i = 0, 1000 back-to-back reqs -> mask_o always 0, mask_valid_o high 1000 cycles, counters 0.
- SINGLE, ber_i = 2, first req -> mask_o = 0x4; flip_cnt_o = 1.
- BURST, ber_i = 2, burst_len_i = 4, hold_i = 3, four reqs -> mask_o = 0x3C four times, then state IDLE. Also: mode_i switched to OFF after the second req -> next mask 0 and state IDLE.
- BURST wrap, SeedBase = 61, ber_i = 100, burst_len_i = 4, hold_i = 0 -> mask_o = 0xC000_0000_0000_0003.
- Counter edges:
  - CntW = 4 with ber_i = 65 -> flip_cnt_o saturates at 0xF on the first mask;
  - clr_cnt_i concurrent with an update -> both counters 0;
  - rst_ni pulsed mid-HOLD -> all outputs 0, and the next req reproduces the first-access mask.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER fault-injection mask generator.
// The run-mask helper builds a contiguous, wrapping run of set bits.
package ber_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_SINGLE = 2'd3
    } ber_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } burst_state_e;

    // Upper bound on mask width that the run-mask helper can produce.
    localparam int unsigned MaxMaskW = 512;
    localparam int unsigned MaxIdxW  = $clog2(MaxMaskW);

    // len bits set from start upward, wrapping modulo width (width is a power of two).
    function automatic logic [MaxMaskW-1:0] run_mask(input int unsigned width,
                                                     input int unsigned start,
                                                     input int unsigned len);
        logic [MaxMaskW-1:0] m;
        logic [MaxIdxW-1:0]  pos;
        m = '0;
        for (int unsigned i = 0; i < MaxMaskW; i++) begin
            if (i < len && i < width) begin
                pos    = MaxIdxW'((start + i) & (width - 1));
                m[pos] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Galois LFSR lane with an optional output scrambling stage.
// Supported state widths: 8, 16, 32 and 64 (maximal-length polynomials).
module lfsr #(
    parameter int unsigned           LfsrWidth    = 64,
    parameter int unsigned           OutWidth     = 64,
    parameter logic [LfsrWidth-1:0]  RstVal       = LfsrWidth'(1),
    parameter int unsigned           CipherLayers = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic [OutWidth-1:0] out_o
);

    function automatic logic [63:0] taps_for(input int unsigned w);
        case (w)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_8020_0003;
            default: return 64'hD800_0000_0000_0000;
        endcase
    endfunction

    localparam logic [LfsrWidth-1:0] Taps = LfsrWidth'(taps_for(LfsrWidth));

    logic [LfsrWidth-1:0] state_q, state_d;
    logic [LfsrWidth-1:0] mix;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ Taps) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RstVal;
        end else begin
            state_q <= state_d;
        end
    end

    // With zero layers the raw state is presented unchanged.
    always_comb begin
        mix = state_q;
        for (int unsigned l = 0; l < CipherLayers; l++) begin
            mix = mix ^ {mix[LfsrWidth-2:0], mix[LfsrWidth-1]} ^ (mix >> 3);
        end
    end

    assign out_o = mix[OutWidth-1:0];

endmodule

// File: rtl/ber_mask_gen.sv
// BER fault-injection mask generator: per-bit random, burst and single-bit
// error masks driven by per-bit LFSR lanes, plus saturating statistics.
module ber_mask_gen
    import ber_pkg::*;
#(
    parameter int unsigned Width     = 64,
    parameter int unsigned LfsrWidth = 64,
    parameter int unsigned SeedBase  = 1,
    parameter int unsigned HoldW     = 8,
    parameter int unsigned CntW      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic [1:0]               mode_i,
    input  logic [LfsrWidth-1:0]     ber_i,
    input  logic [$clog2(Width):0]   burst_len_i,
    input  logic [HoldW-1:0]         hold_i,
    input  logic                     clr_cnt_i,
    output logic [Width-1:0]         mask_o,
    output logic                     mask_valid_o,
    output logic [CntW-1:0]          inj_cnt_o,
    output logic [CntW-1:0]          flip_cnt_o,
    output logic                     dbg_state_o
);

    localparam int unsigned IdxW = $clog2(Width);
    localparam int unsigned LenW = IdxW + 1;
    localparam int unsigned PopW = IdxW + 1;
    localparam int unsigned SumW = ((CntW > PopW) ? CntW : PopW) + 1;

    function automatic logic [PopW-1:0] popcount(input logic [Width-1:0] v);
        logic [PopW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            c = c + PopW'(v[i]);
        end
        return c;
    endfunction

    ber_mode_e mode_e;
    assign mode_e = ber_mode_e'(mode_i);

    // ---------------------------------------------------------------- lanes
    logic                 lane_en;
    logic [LfsrWidth-1:0] lane_val [Width];

    assign lane_en = req_i && (mode_e != MODE_OFF);

    for (genvar k = 0; k < Width; k++) begin : g_lane
        lfsr #(
            .LfsrWidth    (LfsrWidth),
            .OutWidth     (LfsrWidth),
            .RstVal       (LfsrWidth'(SeedBase + k)),
            .CipherLayers (0)
        ) u_lfsr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (lane_en),
            .out_o  (lane_val[k])
        );
    end

    // ------------------------------------------------------ candidate masks
    logic             trigger;
    logic [IdxW-1:0]  idx;
    logic [LenW-1:0]  eff_len;
    logic [Width-1:0] rand_mask;
    logic [Width-1:0] onehot_mask;
    logic [Width-1:0] run_msk;

    assign trigger     = lane_val[0] < ber_i;
    assign idx         = lane_val[1][IdxW-1:0];
    assign onehot_mask = Width'(1) << idx;

    always_comb begin
        for (int unsigned k = 0; k < Width; k++) begin
            rand_mask[k] = lane_val[k] < ber_i;
        end
    end

    always_comb begin
        eff_len = burst_len_i;
        if (burst_len_i == '0) begin
            eff_len = LenW'(1);
        end else if (burst_len_i > LenW'(Width)) begin
            eff_len = LenW'(Width);
        end
    end

    assign run_msk = Width'(run_mask(Width, 32'(idx), 32'(eff_len)));

    // --------------------------------------------------------- burst FSM
    burst_state_e     state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [Width-1:0] burst_q, burst_d;
    logic [Width-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        burst_d = burst_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        if (mode_e == MODE_OFF) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end
        if (req_i) begin
            valid_d = 1'b1;
            case (mode_e)
                MODE_OFF: begin
                    mask_d = '0;
                end
                MODE_RANDOM: begin
                    mask_d  = rand_mask;
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
                MODE_SINGLE: begin
                    mask_d  = trigger ? onehot_mask : '0;
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
                MODE_BURST: begin
                    // While holding, the latched burst repeats and no trigger is drawn.
                    if (state_q == ST_HOLD) begin
                        mask_d = burst_q;
                        hold_d = hold_q - HoldW'(1);
                        if (hold_q == HoldW'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end else if (trigger) begin
                        mask_d  = run_msk;
                        burst_d = run_msk;
                        if (hold_i != '0) begin
                            hold_d  = hold_i;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        mask_d = '0;
                    end
                end
                default: begin
                    mask_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            burst_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------- statistics
    logic [CntW-1:0] inj_q, inj_d;
    logic [CntW-1:0] flip_q, flip_d;
    logic [SumW-1:0] flip_sum;

    assign flip_sum = SumW'(flip_q) + SumW'(popcount(mask_q));

    always_comb begin
        inj_d  = inj_q;
        flip_d = flip_q;
        if (clr_cnt_i) begin
            inj_d  = '0;
            flip_d = '0;
        end else if (valid_q && (mask_q != '0)) begin
            inj_d  = (inj_q == '1) ? inj_q : inj_q + CntW'(1);
            flip_d = (flip_sum > SumW'({CntW{1'b1}})) ? '1 : flip_sum[CntW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inj_q  <= '0;
            flip_q <= '0;
        end else begin
            inj_q  <= inj_d;
            flip_q <= flip_d;
        end
    end

    assign mask_o       = mask_q;
    assign mask_valid_o = valid_q;
    assign inj_cnt_o    = inj_q;
    assign flip_cnt_o   = flip_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ber_mask_gen.sv
// Directed bench for ber_mask_gen: three parameterisations share one stimulus
// bus; table vectors cover single accesses, sequences cover multi-cycle cases.
module tb_ber_mask_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [63:0] ber = '0;
    logic [6:0]  blen = '0;
    logic [7:0]  hold = '0;
    logic        clr = 1'b0;

    logic [63:0] mask_a, mask_b, mask_c;
    logic        val_a, val_b, val_c;
    logic [31:0] inj_a, inj_b, flip_a, flip_b;
    logic [3:0]  inj_c, flip_c;
    logic        st_a, st_b, st_c;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OFF = 2'd0, RND = 2'd1, BST = 2'd2, SGL = 2'd3;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    ber_mask_gen u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode), .ber_i(ber),
        .burst_len_i(blen), .hold_i(hold), .clr_cnt_i(clr), .mask_o(mask_a),
        .mask_valid_o(val_a), .inj_cnt_o(inj_a), .flip_cnt_o(flip_a), .dbg_state_o(st_a)
    );

    ber_mask_gen #(.SeedBase(61)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode), .ber_i(ber),
        .burst_len_i(blen), .hold_i(hold), .clr_cnt_i(clr), .mask_o(mask_b),
        .mask_valid_o(val_b), .inj_cnt_o(inj_b), .flip_cnt_o(flip_b), .dbg_state_o(st_b)
    );

    ber_mask_gen #(.CntW(4)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode), .ber_i(ber),
        .burst_len_i(blen), .hold_i(hold), .clr_cnt_i(clr), .mask_o(mask_c),
        .mask_valid_o(val_c), .inj_cnt_o(inj_c), .flip_cnt_o(flip_c), .dbg_state_o(st_c)
    );

    function automatic logic [63:0] g_mask(input int inst);
        case (inst)
            1:       return mask_b;
            2:       return mask_c;
            default: return mask_a;
        endcase
    endfunction

    function automatic logic [63:0] g_valid(input int inst);
        case (inst)
            1:       return 64'(val_b);
            2:       return 64'(val_c);
            default: return 64'(val_a);
        endcase
    endfunction

    function automatic logic [63:0] g_inj(input int inst);
        case (inst)
            1:       return 64'(inj_b);
            2:       return 64'(inj_c);
            default: return 64'(inj_a);
        endcase
    endfunction

    function automatic logic [63:0] g_flip(input int inst);
        case (inst)
            1:       return 64'(flip_b);
            2:       return 64'(flip_c);
            default: return 64'(flip_a);
        endcase
    endfunction

    function automatic logic [63:0] g_state(input int inst);
        case (inst)
            1:       return 64'(st_b);
            2:       return 64'(st_c);
            default: return 64'(st_a);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 1'b0;
        clr   = 1'b0;
        mode  = OFF;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [63:0] b,
                           input logic [6:0] l, input logic [7:0] h);
        mode = m;
        ber  = b;
        blen = l;
        hold = h;
    endtask

    typedef struct {
        string       name;
        int          inst;
        logic [1:0]  mode;
        logic [63:0] ber;
        logic [6:0]  len;
        logic [7:0]  hold;
        logic [63:0] exp_mask;
        logic [63:0] exp_inj;
        logic [63:0] exp_flip;
        logic [63:0] exp_state;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{"rnd_ber33",      0, RND, 64'd33,  7'd0,   8'd0, 64'h0000_0000_FFFF_FFFF, 1, 32, 0};
        vecs[1]  = '{"single_ber2",    0, SGL, 64'd2,   7'd0,   8'd0, 64'h4,                   1, 1,  0};
        vecs[2]  = '{"rnd_ber1",       0, RND, 64'd1,   7'd0,   8'd0, 64'h0,                   0, 0,  0};
        vecs[3]  = '{"rnd_ber0",       0, RND, 64'd0,   7'd0,   8'd0, 64'h0,                   0, 0,  0};
        vecs[4]  = '{"burst_len0",     0, BST, 64'd2,   7'd0,   8'd0, 64'h4,                   1, 1,  0};
        vecs[5]  = '{"burst_len64",    0, BST, 64'd2,   7'd64,  8'd0, ONES,                    1, 64, 0};
        vecs[6]  = '{"burst_len127",   0, BST, 64'd2,   7'd127, 8'd0, ONES,                    1, 64, 0};
        vecs[7]  = '{"burst_notrig",   0, BST, 64'd1,   7'd4,   8'd2, 64'h0,                   0, 0,  0};
        vecs[8]  = '{"rnd_ber65",      0, RND, 64'd65,  7'd0,   8'd0, ONES,                    1, 64, 0};
        vecs[9]  = '{"off_ber65",      0, OFF, 64'd65,  7'd4,   8'd0, 64'h0,                   0, 0,  0};
        vecs[10] = '{"rnd_ber3",       0, RND, 64'd3,   7'd0,   8'd0, 64'h3,                   1, 2,  0};
        vecs[11] = '{"burst_hold5",    0, BST, 64'd2,   7'd4,   8'd5, 64'h3C,                  1, 4,  1};
        vecs[12] = '{"wrap_seed61",    1, BST, 64'd100, 7'd4,   8'd0, 64'hC000_0000_0000_0003, 1, 4,  0};
        vecs[13] = '{"single_seed61",  1, SGL, 64'd100, 7'd0,   8'd0, 64'h4000_0000_0000_0000, 1, 1,  0};
        vecs[14] = '{"rnd_seed61",     1, RND, 64'd63,  7'd0,   8'd0, 64'h3,                   1, 2,  0};
        vecs[15] = '{"sat_cntw4",      2, RND, 64'd65,  7'd0,   8'd0, ONES,                    1, 15, 0};
    end

    initial begin
        int nz_cnt;
        int val_cnt;

        // Reset state
        do_reset();
        check("rst_mask_a", mask_a, 64'h0);
        check("rst_valid_a", 64'(val_a), 64'h0);
        check("rst_inj_a", 64'(inj_a), 64'h0);
        check("rst_flip_a", 64'(flip_a), 64'h0);
        check("rst_state_a", 64'(st_a), 64'h0);

        // Table vectors: one access from reset each
        for (int i = 0; i < NV; i++) begin
            do_reset();
            @(negedge clk);
            set_cfg(vecs[i].mode, vecs[i].ber, vecs[i].len, vecs[i].hold);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            check({vecs[i].name, "_mask"},  g_mask(vecs[i].inst),  vecs[i].exp_mask);
            check({vecs[i].name, "_valid"}, g_valid(vecs[i].inst), 64'h1);
            check({vecs[i].name, "_state"}, g_state(vecs[i].inst), vecs[i].exp_state);
            @(negedge clk);
            check({vecs[i].name, "_inj"},   g_inj(vecs[i].inst),   vecs[i].exp_inj);
            check({vecs[i].name, "_flip"},  g_flip(vecs[i].inst),  vecs[i].exp_flip);
            check({vecs[i].name, "_vlow"},  g_valid(vecs[i].inst), 64'h0);
            check({vecs[i].name, "_mhold"}, g_mask(vecs[i].inst),  vecs[i].exp_mask);
        end

        // ber_i = 0 with 1000 back-to-back requests
        do_reset();
        nz_cnt  = 0;
        val_cnt = 0;
        @(negedge clk);
        set_cfg(RND, 64'd0, 7'd0, 8'd0);
        req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 999) req = 1'b0;
            if (val_a) val_cnt++;
            if (mask_a != '0) nz_cnt++;
        end
        @(negedge clk);
        check("b2b_valid_cycles", 64'(val_cnt), 64'd1000);
        check("b2b_nonzero_masks", 64'(nz_cnt), 64'd0);
        check("b2b_vlow", 64'(val_a), 64'h0);
        check("b2b_inj", 64'(inj_a), 64'h0);
        check("b2b_flip", 64'(flip_a), 64'h0);

        // Burst with hold 3: four identical masks, then back to IDLE
        do_reset();
        @(negedge clk);
        set_cfg(BST, 64'd2, 7'd4, 8'd3);
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) req = 1'b0;
            check($sformatf("hold_mask_%0d", i), mask_a, 64'h3C);
            check($sformatf("hold_valid_%0d", i), 64'(val_a), 64'h1);
            check($sformatf("hold_state_%0d", i), 64'(st_a), (i == 3) ? 64'h0 : 64'h1);
        end
        @(negedge clk);
        check("hold_inj", 64'(inj_a), 64'd4);
        check("hold_flip", 64'(flip_a), 64'd16);

        // Switching to OFF while holding aborts the burst
        do_reset();
        @(negedge clk);
        set_cfg(BST, 64'd2, 7'd4, 8'd3);
        req = 1'b1;
        @(negedge clk);
        check("abort_mask_1", mask_a, 64'h3C);
        @(negedge clk);
        check("abort_mask_2", mask_a, 64'h3C);
        check("abort_state_2", 64'(st_a), 64'h1);
        mode = OFF;
        @(negedge clk);
        req = 1'b0;
        check("abort_mask_off", mask_a, 64'h0);
        check("abort_valid_off", 64'(val_a), 64'h1);
        check("abort_state_off", 64'(st_a), 64'h0);

        // Clear concurrent with a counter update
        do_reset();
        @(negedge clk);
        set_cfg(RND, 64'd33, 7'd0, 8'd0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        clr = 1'b1;
        check("clr_mask", mask_a, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        clr = 1'b0;
        check("clr_inj", 64'(inj_a), 64'h0);
        check("clr_flip", 64'(flip_a), 64'h0);

        // Asynchronous reset in the middle of a hold
        do_reset();
        @(negedge clk);
        set_cfg(BST, 64'd2, 7'd4, 8'd3);
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_inj", 64'(inj_a), 64'd1);
        check("midrst_pre_flip", 64'(flip_a), 64'd4);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("midrst_mask", mask_a, 64'h0);
        check("midrst_valid", 64'(val_a), 64'h0);
        check("midrst_inj", 64'(inj_a), 64'h0);
        check("midrst_flip", 64'(flip_a), 64'h0);
        check("midrst_state", 64'(st_a), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("midrst_again_mask", mask_a, 64'h3C);
        check("midrst_again_state", 64'(st_a), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
